calculation_unit_exponent_normalizer: RTL and testbench
=======================================================

Name: calculation_unit_exponent_normalizer

Overview:
- Two-stage pipelined stage directly downstream of the calculation-unit exponent select.
- Takes the 10-bit signed biased calculated exponent plus the mantissa normalization info (carry-out, leading-zero shift) and produces the final 8-bit biased exponent, overflow/underflow classification and denormal right-shift amount for the rounding stage.
- Valid/ready handshake on both sides; full throughput of 1 op/cycle.

Parameters:
- DENORMAL_SHIFT_MAX, 26, saturation limit for denormal_shift (mantissa width + guard bits).

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- valid_in  input  1  upstream operation valid
- ready_out  output  1  this block can accept valid_in this cycle
- calculation_select  input  calculation::calculation_select  operation tag, passed through
- calculated_exponent  input  10  two's-complement biased exponent from exponent select
- mantissa_carry  input  1  mantissa overflowed; exponent +1
- mantissa_shift  input  5  leading-zero left-shift amount; exponent -shift
- valid_out  output  1  result valid
- ready_in  input  1  downstream accepts result
- calculation_select_out  output  calculation::calculation_select  tag, aligned with result
- normalized_exponent  output  8  final biased exponent
- overflow  output  1  result exponent saturated to 255
- underflow  output  1  result tiny (adjusted exponent <= 0)
- denormal_shift  output  5  right-shift to apply to mantissa for denormal result
- zero_flush  output  1  result flushed to zero (see Optional Feature)

Behaviour:
- Reset (async, reset_n low): s1_valid, s2_valid, valid_out = 0; all data registers and outputs = 0; ready_out = 1 after reset release. Reset mid-operation discards all in-flight ops; no output is produced for them.
- Handshake: a transfer occurs on valid_in & ready_out (input) and valid_out & ready_in (output).
  - s2_advance = ~s2_valid | ready_in.
  - s1_advance = ~s1_valid | s2_advance.
  - ready_out = s1_advance (combinational).
  - Data is held stable while valid_out & ~ready_in. No drops, no duplicates, order preserved.
- Stage 1 (register on s1_advance):
  - adjusted = sext11(calculated_exponent) + mantissa_carry - zext11(mantissa_shift), computed as an 11-bit signed value, so there is no wrap over the full input range (-543..512).
  - Also registers calculation_select.
  - s1_valid <= valid_in.
- Stage 2 (register on s2_advance, classification of adjusted):
  - adjusted >= 255: overflow=1, underflow=0, normalized_exponent=255, denormal_shift=0.
  - adjusted <= 0: underflow=1, overflow=0, normalized_exponent=0, denormal_shift=min(1-adjusted, DENORMAL_SHIFT_MAX).
  - 1..254: normalized_exponent=adjusted[7:0], flags 0, denormal_shift=0.
  - s2_valid <= s1_valid; valid_out = s2_valid.
- Latency: 2 cycles from input transfer to valid_out when ready_in is held high.
- Simultaneous input and output transfer while both stages are full is permitted; the pipeline shifts by one.
- Bubbles (valid_in=0) propagate as invalid; their data registers may update but outputs are only meaningful when valid_out=1.

Optional Feature:
- Macro: CALCULATION_UNIT_FLUSH_TO_ZERO_EN.
- Defined: underflow results set zero_flush=1, denormal_shift=0, normalized_exponent=0; underflow is still asserted.
- Undefined: zero_flush is tied 0 and denormal_shift is computed as above.

Decomposition:
- The calculation package gains the constants EXPONENT_MAX=255 and EXPONENT_ADJUST_WIDTH=11.
- DENORMAL_SHIFT_MAX stays a parameter.
- One combinational sub-module: calculation_unit_exponent_classifier (11-bit adjusted in; exponent, overflow, underflow, denormal_shift, zero_flush out), instantiated before the stage-2 registers.

Test Plan:
- Normal path: calculated_exponent=130, shift=3, carry=0, ready_in=1 -> 2 cycles later normalized_exponent=127, overflow=0, underflow=0.
- Overflow: calculated_exponent=254, carry=1 -> normalized_exponent=255, overflow=1. Also calculated_exponent=400 -> overflow=1.
- Denormal: calculated_exponent=-5 (10'h3FB), shift=0 -> underflow=1, normalized_exponent=0, denormal_shift=6. calculated_exponent=-40 -> denormal_shift=26 (saturated). With the macro defined, both cases give zero_flush=1 and denormal_shift=0.
- Backpressure: stream 4 ops back-to-back, ready_in=0 for 3 cycles -> ready_out drops after 2 ops are held, outputs stay stable, all 4 results emerge in order with none lost or duplicated.
- Reset mid-flight: assert reset_n=0 with 2 ops in flight -> valid_out=0 immediately (async); after release, the next op completes with 2-cycle latency and no stale results appear.

Source files
------------

// File: rtl/calculation_unit_exponent_normalizer_pkg.sv
// Shared calculation-unit types and exponent constants used by the exponent normalizer slice.
package calculation;

  typedef enum logic [2:0] {
    CALC_ADD  = 3'd0,
    CALC_SUB  = 3'd1,
    CALC_MUL  = 3'd2,
    CALC_DIV  = 3'd3,
    CALC_SQRT = 3'd4
  } calculation_select;

  localparam int EXPONENT_MAX          = 255;
  localparam int EXPONENT_ADJUST_WIDTH = 11;

endpackage

// File: rtl/calculation_unit_exponent_normalizer_classifier.sv
// Combinational classification of the adjusted exponent into final exponent, range flags and denormal shift.
// Build macro CALCULATION_UNIT_FLUSH_TO_ZERO_EN flushes tiny results to zero instead of denormalising.
module calculation_unit_exponent_classifier
  import calculation::*;
#(
  parameter int DENORMAL_SHIFT_MAX = 26
) (
  input  logic signed [EXPONENT_ADJUST_WIDTH-1:0] adjusted,
  output logic [7:0]                              exponent,
  output logic                                    overflow,
  output logic                                    underflow,
  output logic [4:0]                              denormal_shift,
  output logic                                    zero_flush
);

  localparam logic signed [11:0] EXP_MAX_S = 12'(EXPONENT_MAX);

  logic signed [11:0] adjusted_wide_s;

  // One extra bit keeps 1 - adjusted from wrapping at the most negative input.
  assign adjusted_wide_s = {adjusted[EXPONENT_ADJUST_WIDTH-1], adjusted};

`ifndef CALCULATION_UNIT_FLUSH_TO_ZERO_EN
  localparam logic signed [11:0] SHIFT_MAX_S = 12'(DENORMAL_SHIFT_MAX);
  logic signed [11:0] tiny_shift_s;
  assign tiny_shift_s = 12'sd1 - adjusted_wide_s;
`endif

  // Range classification: saturate high, denormalise or flush low, pass through otherwise.
  always_comb begin
    exponent       = 8'd0;
    overflow       = 1'b0;
    underflow      = 1'b0;
    denormal_shift = 5'd0;
    zero_flush     = 1'b0;
    if (adjusted_wide_s >= EXP_MAX_S) begin
      overflow = 1'b1;
      exponent = 8'(EXPONENT_MAX);
    end else if (adjusted_wide_s <= 12'sd0) begin
      underflow = 1'b1;
`ifdef CALCULATION_UNIT_FLUSH_TO_ZERO_EN
      zero_flush = 1'b1;
`else
      if (tiny_shift_s > SHIFT_MAX_S) begin
        denormal_shift = 5'(DENORMAL_SHIFT_MAX);
      end else begin
        denormal_shift = tiny_shift_s[4:0];
      end
`endif
    end else begin
      exponent = adjusted_wide_s[7:0];
    end
  end

endmodule

// File: rtl/calculation_unit_exponent_normalizer.sv
// Two-stage valid/ready pipeline: stage 1 applies mantissa normalisation to the exponent, stage 2 registers its classification.
// Build macro CALCULATION_UNIT_FLUSH_TO_ZERO_EN selects flush-to-zero for tiny results.
module calculation_unit_exponent_normalizer #(
  parameter int DENORMAL_SHIFT_MAX = 26
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          valid_in,
  output logic                          ready_out,
  input  calculation::calculation_select calculation_select,
  input  logic [9:0]                    calculated_exponent,
  input  logic                          mantissa_carry,
  input  logic [4:0]                    mantissa_shift,
  output logic                          valid_out,
  input  logic                          ready_in,
  output calculation::calculation_select calculation_select_out,
  output logic [7:0]                    normalized_exponent,
  output logic                          overflow,
  output logic                          underflow,
  output logic [4:0]                    denormal_shift,
  output logic                          zero_flush
);

  localparam int AW = calculation::EXPONENT_ADJUST_WIDTH;

  logic                           s1_valid_r;
  logic signed [AW-1:0]           s1_adjusted_r;
  calculation::calculation_select s1_select_r;
  logic signed [AW-1:0]           adjusted_s;
  logic                           s1_advance_s;
  logic                           s2_advance_s;
  logic [7:0]                     cls_exponent_s;
  logic                           cls_overflow_s;
  logic                           cls_underflow_s;
  logic [4:0]                     cls_denormal_shift_s;
  logic                           cls_zero_flush_s;

  assign s2_advance_s = ~valid_out | ready_in;
  assign s1_advance_s = ~s1_valid_r | s2_advance_s;
  assign ready_out    = s1_advance_s;

  // Sign-extended sum is wide enough that no input combination wraps.
  assign adjusted_s = {calculated_exponent[9], calculated_exponent}
                    + {10'd0, mantissa_carry}
                    - {6'd0, mantissa_shift};

  // Stage 1: capture the adjusted exponent and operation tag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_r    <= 1'b0;
      s1_adjusted_r <= '0;
      s1_select_r   <= calculation::CALC_ADD;
    end else if (s1_advance_s) begin
      s1_valid_r    <= valid_in;
      s1_adjusted_r <= adjusted_s;
      s1_select_r   <= calculation_select;
    end
  end

  calculation_unit_exponent_classifier #(
    .DENORMAL_SHIFT_MAX(DENORMAL_SHIFT_MAX)
  ) u_classifier (
    .adjusted      (s1_adjusted_r),
    .exponent      (cls_exponent_s),
    .overflow      (cls_overflow_s),
    .underflow     (cls_underflow_s),
    .denormal_shift(cls_denormal_shift_s),
    .zero_flush    (cls_zero_flush_s)
  );

  // Stage 2: registered result; holds while the consumer stalls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_out              <= 1'b0;
      calculation_select_out <= calculation::CALC_ADD;
      normalized_exponent    <= 8'd0;
      overflow               <= 1'b0;
      underflow              <= 1'b0;
      denormal_shift         <= 5'd0;
      zero_flush             <= 1'b0;
    end else if (s2_advance_s) begin
      valid_out              <= s1_valid_r;
      calculation_select_out <= s1_select_r;
      normalized_exponent    <= cls_exponent_s;
      overflow               <= cls_overflow_s;
      underflow              <= cls_underflow_s;
      denormal_shift         <= cls_denormal_shift_s;
      zero_flush             <= cls_zero_flush_s;
    end
  end

endmodule

// File: tb/tb_calculation_unit_exponent_normalizer.sv
// Directed-vector bench with an arithmetic reference model and a per-cycle scoreboard for the exponent normalizer.
module tb_calculation_unit_exponent_normalizer;

  typedef struct {
    logic [9:0] e;
    logic       c;
    logic [4:0] s;
    logic [7:0] ne;
    logic       ov;
    logic       un;
    logic [4:0] ds;
  } vec_t;

  typedef struct {
    logic [7:0]                     ne;
    logic                           ov;
    logic                           un;
    logic [4:0]                     ds;
    logic                           zf;
    calculation::calculation_select sel;
    int                             cyc;
    bit                             has_lit;
    vec_t                           lit;
  } exp_t;

  logic                           clk = 1'b0;
  logic                           reset_n;
  logic                           valid_in;
  logic                           ready_out;
  calculation::calculation_select sel_in;
  logic [9:0]                     calc_exp;
  logic                           carry;
  logic [4:0]                     shift;
  logic                           valid_out;
  logic                           ready_in;
  calculation::calculation_select sel_out;
  logic [7:0]                     norm_exp;
  logic                           ovf;
  logic                           unf;
  logic [4:0]                     dshift;
  logic                           zflush;

  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  bit   lat_en = 1'b1;
  bit   cur_lit;
  vec_t cur_vec;
  exp_t exp_q[$];
  vec_t vecs[15];

  calculation_unit_exponent_normalizer #(.DENORMAL_SHIFT_MAX(26)) dut (
    .clk                   (clk),
    .reset_n               (reset_n),
    .valid_in              (valid_in),
    .ready_out             (ready_out),
    .calculation_select    (sel_in),
    .calculated_exponent   (calc_exp),
    .mantissa_carry        (carry),
    .mantissa_shift        (shift),
    .valid_out             (valid_out),
    .ready_in              (ready_in),
    .calculation_select_out(sel_out),
    .normalized_exponent   (norm_exp),
    .overflow              (ovf),
    .underflow             (unf),
    .denormal_shift        (dshift),
    .zero_flush            (zflush)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the exponent rules.
  function automatic exp_t model(input logic [9:0] e, input logic c, input logic [4:0] s);
    exp_t r;
    int   adj;
    adj = int'($signed(e)) + (c ? 1 : 0) - int'(s);
    r.ne = 8'd0; r.ov = 1'b0; r.un = 1'b0; r.ds = 5'd0; r.zf = 1'b0;
    if (adj >= 255) begin
      r.ne = 8'd255; r.ov = 1'b1;
    end else if (adj <= 0) begin
      r.un = 1'b1;
`ifdef CALCULATION_UNIT_FLUSH_TO_ZERO_EN
      r.zf = 1'b1;
`else
      r.ds = 5'((1 - adj) > 26 ? 26 : (1 - adj));
`endif
    end else begin
      r.ne = 8'(adj);
    end
    return r;
  endfunction

  // Scoreboard: push on input transfer, check the head every valid cycle, pop on output transfer.
  always @(negedge clk) begin
    exp_t h;
    cyc++;
    if (!reset_n) begin
      exp_q.delete();
      chk("reset_valid_out", 32'(valid_out), 32'd0);
    end else begin
      if (valid_out) begin
        if (exp_q.size() == 0) begin
          chk("spurious_valid_out", 32'(valid_out), 32'd0);
        end else begin
          h = exp_q[0];
          chk("norm_exp", 32'(norm_exp), 32'(h.ne));
          chk("overflow", 32'(ovf), 32'(h.ov));
          chk("underflow", 32'(unf), 32'(h.un));
          chk("denormal_shift", 32'(dshift), 32'(h.ds));
          chk("zero_flush", 32'(zflush), 32'(h.zf));
          chk("select_out", 32'(sel_out), 32'(h.sel));
          if (h.has_lit) begin
            chk("lit_norm_exp", 32'(norm_exp), 32'(h.lit.ne));
            chk("lit_overflow", 32'(ovf), 32'(h.lit.ov));
            chk("lit_underflow", 32'(unf), 32'(h.lit.un));
`ifdef CALCULATION_UNIT_FLUSH_TO_ZERO_EN
            chk("lit_denormal_shift", 32'(dshift), 32'(h.lit.un ? 5'd0 : h.lit.ds));
            chk("lit_zero_flush", 32'(zflush), 32'(h.lit.un));
`else
            chk("lit_denormal_shift", 32'(dshift), 32'(h.lit.ds));
            chk("lit_zero_flush", 32'(zflush), 32'd0);
`endif
          end
          if (ready_in) begin
            if (lat_en) chk("latency", 32'(cyc - h.cyc), 32'd2);
            void'(exp_q.pop_front());
          end
        end
      end
      if (valid_in && ready_out) begin
        h = model(calc_exp, carry, shift);
        h.sel = sel_in;
        h.cyc = cyc;
        h.has_lit = cur_lit;
        h.lit = cur_vec;
        exp_q.push_back(h);
      end
    end
  end

  task automatic drive(input vec_t v, input bit lit, input int tag);
    calc_exp = v.e;
    carry    = v.c;
    shift    = v.s;
    sel_in   = calculation::calculation_select'(3'(tag % 5));
    cur_vec  = v;
    cur_lit  = lit;
    valid_in = 1'b1;
  endtask

  task automatic send(input vec_t v, input bit lit, input int tag);
    bit accepted = 1'b0;
    drive(v, lit, tag);
    for (int k = 0; k < 20 && !accepted; k++) begin
      @(negedge clk);
      if (ready_out) accepted = 1'b1;
      @(posedge clk);
      #1;
    end
    valid_in = 1'b0;
    if (!accepted) chk("send_timeout", 32'(accepted), 32'd1);
  endtask

  task automatic drain();
    int k = 0;
    while ((exp_q.size() != 0 || valid_out) && k < 60) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    vecs[0]  = '{10'd130,   1'b0, 5'd3,  8'd127, 1'b0, 1'b0, 5'd0};
    vecs[1]  = '{10'd254,   1'b1, 5'd0,  8'd255, 1'b1, 1'b0, 5'd0};
    vecs[2]  = '{10'd400,   1'b0, 5'd0,  8'd255, 1'b1, 1'b0, 5'd0};
    vecs[3]  = '{10'h3FB,   1'b0, 5'd0,  8'd0,   1'b0, 1'b1, 5'd6};
    vecs[4]  = '{10'h3D8,   1'b0, 5'd0,  8'd0,   1'b0, 1'b1, 5'd26};
    vecs[5]  = '{10'd1,     1'b0, 5'd0,  8'd1,   1'b0, 1'b0, 5'd0};
    vecs[6]  = '{10'd254,   1'b0, 5'd0,  8'd254, 1'b0, 1'b0, 5'd0};
    vecs[7]  = '{10'd0,     1'b0, 5'd0,  8'd0,   1'b0, 1'b1, 5'd1};
    vecs[8]  = '{10'd1,     1'b0, 5'd1,  8'd0,   1'b0, 1'b1, 5'd1};
    vecs[9]  = '{10'h200,   1'b0, 5'd31, 8'd0,   1'b0, 1'b1, 5'd26};
    vecs[10] = '{10'h1FF,   1'b1, 5'd0,  8'd255, 1'b1, 1'b0, 5'd0};
    vecs[11] = '{10'h3E8,   1'b0, 5'd0,  8'd0,   1'b0, 1'b1, 5'd25};
    vecs[12] = '{10'h3E7,   1'b0, 5'd0,  8'd0,   1'b0, 1'b1, 5'd26};
    vecs[13] = '{10'd10,    1'b1, 5'd11, 8'd0,   1'b0, 1'b1, 5'd1};
    vecs[14] = '{10'd200,   1'b1, 5'd31, 8'd170, 1'b0, 1'b0, 5'd0};

    reset_n  = 1'b0;
    valid_in = 1'b0;
    ready_in = 1'b1;
    drive(vecs[0], 1'b0, 0);
    valid_in = 1'b0;
    #1;
    chk("rst_valid_out", 32'(valid_out), 32'd0);
    chk("rst_norm_exp", 32'(norm_exp), 32'd0);
    chk("rst_flags", 32'({ovf, unf, zflush}), 32'd0);
    chk("rst_denormal_shift", 32'(dshift), 32'd0);
    chk("rst_ready_out", 32'(ready_out), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Back-to-back directed vectors, then a few with bubbles between them.
    for (int i = 0; i < 15; i++) send(vecs[i], 1'b1, i);
    for (int i = 0; i < 4; i++) begin
      send(vecs[i * 3], 1'b1, i + 1);
      @(posedge clk);
      #1;
    end
    drain();

    // Backpressure: two ops fill the pipe, a third waits three stalled cycles.
    lat_en   = 1'b0;
    ready_in = 1'b0;
    send(vecs[0], 1'b1, 0);
    send(vecs[3], 1'b1, 1);
    drive(vecs[1], 1'b1, 2);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_ready_out", 32'(ready_out), 32'd0);
      @(posedge clk);
      #1;
    end
    ready_in = 1'b1;
    send(vecs[1], 1'b1, 2);
    send(vecs[4], 1'b1, 3);
    drain();
    lat_en = 1'b1;

    // Reset with two ops in flight; none may surface afterwards.
    send(vecs[5], 1'b1, 0);
    send(vecs[6], 1'b1, 1);
    reset_n = 1'b0;
    #1;
    chk("midrst_valid_out", 32'(valid_out), 32'd0);
    chk("midrst_ready_out", 32'(ready_out), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    send(vecs[0], 1'b1, 4);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
